wb_write_port: RTL and testbench

Writeback arbiter that produces the single register-file write port (`regWrite`, `RD`, `writeData`) from two result sources: the in-order ALU/commit path and the long-latency multiply/divide unit (MDU). MDU results are queued in a small FIFO and drained whenever the ALU does not claim the write port. A per-register busy scoreboard lets decode stall on operands whose MDU result is still pending.

---
 rtl/wb_write_port.sv | 144 ++++++++++++++
 tb/tb_wb_write_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_port.sv
// Writeback arbiter: merges ALU and queued MDU results onto one register-file write port,
// with a busy scoreboard for pending MDU writes. Optional direct MDU bypass via WB_BYPASS_EN.
module wb_write_port #(
    parameter int n     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [n-1:0]               alu_data,
    input  logic                       mdu_issue,
    input  logic [4:0]                 mdu_issue_rd,
    input  logic                       mdu_valid,
    output logic                       mdu_ready,
    input  logic [4:0]                 mdu_rd,
    input  logic [n-1:0]               mdu_data,
    output logic                       regWrite,
    output logic [4:0]                 RD,
    output logic [n-1:0]               writeData,
    output logic [31:0]                busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]    fifo_rd   [DEPTH];
    logic [n-1:0]  fifo_data [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    logic          alu_claim;
    logic          fifo_empty;
    logic          push;
    logic          push_q;
    logic          pop;
    logic          byp;
    logic [4:0]    head_rd;
    logic [n-1:0]  head_data;
    logic [31:0]   set_mask;
    logic [31:0]   clr_mask;
    logic [31:0]   busy_next;
    logic          err_now;

    assign alu_claim  = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty = (fifo_count == '0);
    assign mdu_ready  = (fifo_count != (AW+1)'(DEPTH));
    assign push       = mdu_valid && mdu_ready;
    assign pop        = !alu_claim && !fifo_empty;
    assign head_rd    = fifo_rd[rptr];
    assign head_data  = fifo_data[rptr];

`ifdef WB_BYPASS_EN
    // An idle port with nothing queued lets the MDU result skip the FIFO entirely.
    assign byp = push && fifo_empty && !alu_claim;
`else
    assign byp = 1'b0;
`endif

    assign push_q = push && !byp;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (mdu_issue && (mdu_issue_rd != 5'd0))
            set_mask = 32'd1 << mdu_issue_rd;
        if (pop)
            clr_mask = 32'd1 << head_rd;
        else if (byp)
            clr_mask = 32'd1 << mdu_rd;
        // Set after clear so a same-cycle re-issue keeps the register busy.
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        err_now = 1'b0;
        if (alu_claim && busy[alu_rd])
            err_now = 1'b1;
        if (mdu_issue && (mdu_issue_rd != 5'd0) && busy[mdu_issue_rd] && !clr_mask[mdu_issue_rd])
            err_now = 1'b1;
        if (mdu_valid && (mdu_rd != 5'd0) && !busy[mdu_rd])
            err_now = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_q) begin
            fifo_rd[wptr]   <= mdu_rd;
            fifo_data[wptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push_q)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push_q && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push_q)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regWrite  <= 1'b0;
            RD        <= 5'd0;
            writeData <= '0;
        end else if (alu_claim) begin
            regWrite  <= 1'b1;
            RD        <= alu_rd;
            writeData <= alu_data;
        end else if (pop) begin
            regWrite  <= (head_rd != 5'd0);
            RD        <= head_rd;
            writeData <= head_data;
        end else if (byp) begin
            regWrite  <= (mdu_rd != 5'd0);
            RD        <= mdu_rd;
            writeData <= mdu_data;
        end else begin
            regWrite  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            if (err_now)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_write_port.sv
// Directed self-checking bench for wb_write_port; expectations are hand-computed per scenario.
module tb_wb_write_port;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        regWrite;
    logic [4:0]  RD;
    logic [31:0] writeData;
    logic [31:0] busy;
    logic [2:0]  fifo_count;
    logic        err;

    int checks;
    int errors;

    wb_write_port #(.n(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .regWrite(regWrite), .RD(RD), .writeData(writeData),
        .busy(busy), .fifo_count(fifo_count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it, so inputs and checks sit away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid    = 1'b0;
        alu_rd       = 5'd0;
        alu_data     = 32'd0;
        mdu_issue    = 1'b0;
        mdu_issue_rd = 5'd0;
        mdu_valid    = 1'b0;
        mdu_rd       = 5'd0;
        mdu_data     = 32'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_regWrite got %b want 0", regWrite); end
        checks++; if (RD !== 5'd0) begin errors++; $display("[TB] FAIL reset_RD got %0d want 0", RD); end
        checks++; if (writeData !== 32'd0) begin errors++; $display("[TB] FAIL reset_writeData got %h want 0", writeData); end
        checks++; if (busy !== 32'd0) begin errors++; $display("[TB] FAIL reset_busy got %h want 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", fifo_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", err); end
        checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", mdu_ready); end
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        checks++; if ({regWrite, RD, writeData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL alu_write got %b/%0d/%h want 1/5/deadbeef", regWrite, RD, writeData); end
        alu_rd = 5'd0; alu_data = 32'h1;
        tick();
        checks++; if ({regWrite, RD, writeData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL alu_rd0 got %b/%0d/%h want 0/5/deadbeef", regWrite, RD, writeData); end
        idle_inputs();
        tick();
    endtask

    task automatic test_contention();
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
        tick();
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("[TB] FAIL cont_issue busy7 got %b want 1", busy[7]); end
        mdu_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'd100;
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
        tick();
        checks++; if ({regWrite, RD, writeData} !== {1'b1, 5'd1, 32'd100}) begin errors++; $display("[TB] FAIL cont_alu1 got %b/%0d/%h want 1/1/64", regWrite, RD, writeData); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL cont_count got %0d want 1", fifo_count); end
        mdu_valid = 1'b0;
        alu_rd = 5'd2; alu_data = 32'd200;
        tick();
        checks++; if ({RD, busy[7]} !== {5'd2, 1'b1}) begin errors++; $display("[TB] FAIL cont_alu2 got rd %0d busy7 %b want 2/1", RD, busy[7]); end
        alu_rd = 5'd3; alu_data = 32'd300;
        tick();
        checks++; if ({RD, busy[7]} !== {5'd3, 1'b1}) begin errors++; $display("[TB] FAIL cont_alu3 got rd %0d busy7 %b want 3/1", RD, busy[7]); end
        alu_valid = 1'b0;
        tick();
        checks++; if ({regWrite, RD, writeData} !== {1'b1, 5'd7, 32'h1234}) begin errors++; $display("[TB] FAIL cont_mdu got %b/%0d/%h want 1/7/1234", regWrite, RD, writeData); end
        checks++; if ({busy[7], fifo_count} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL cont_drained got busy7 %b count %0d want 0/0", busy[7], fifo_count); end
        idle_inputs();
        tick();
        checks++; if ({regWrite, err} !== 2'b00) begin errors++; $display("[TB] FAIL cont_idle got we %b err %b want 0/0", regWrite, err); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            mdu_issue = 1'b1; mdu_issue_rd = 5'(10 + i);
            tick();
        end
        mdu_issue = 1'b0;
        checks++; if (busy !== 32'h00007C00) begin errors++; $display("[TB] FAIL bp_busy got %h want 00007c00", busy); end
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA;
        for (int i = 0; i < 4; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(10 + i); mdu_data = 32'(32'h100 + i);
            checks++; if (mdu_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready%0d got %b want 1", i, mdu_ready); end
            tick();
        end
        checks++; if ({mdu_ready, fifo_count} !== {1'b0, 3'd4}) begin errors++; $display("[TB] FAIL bp_full got ready %b count %0d want 0/4", mdu_ready, fifo_count); end
        mdu_rd = 5'd14; mdu_data = 32'h104;
        tick();
        checks++; if ({mdu_ready, fifo_count, RD} !== {1'b0, 3'd4, 5'd20}) begin errors++; $display("[TB] FAIL bp_hold got ready %b count %0d rd %0d want 0/4/20", mdu_ready, fifo_count, RD); end
        alu_valid = 1'b0;
        tick();
        checks++; if ({regWrite, RD, writeData, fifo_count} !== {1'b1, 5'd10, 32'h100, 3'd3}) begin errors++; $display("[TB] FAIL bp_pop0 got %b/%0d/%h/%0d want 1/10/100/3", regWrite, RD, writeData, fifo_count); end
        tick();
        checks++; if ({regWrite, RD, writeData, fifo_count} !== {1'b1, 5'd11, 32'h101, 3'd3}) begin errors++; $display("[TB] FAIL bp_pop1 got %b/%0d/%h/%0d want 1/11/101/3", regWrite, RD, writeData, fifo_count); end
        mdu_valid = 1'b0;
        tick();
        checks++; if ({RD, writeData, fifo_count} !== {5'd12, 32'h102, 3'd2}) begin errors++; $display("[TB] FAIL bp_pop2 got %0d/%h/%0d want 12/102/2", RD, writeData, fifo_count); end
        tick();
        checks++; if ({RD, writeData, fifo_count} !== {5'd13, 32'h103, 3'd1}) begin errors++; $display("[TB] FAIL bp_pop3 got %0d/%h/%0d want 13/103/1", RD, writeData, fifo_count); end
        tick();
        checks++; if ({regWrite, RD, writeData, fifo_count} !== {1'b1, 5'd14, 32'h104, 3'd0}) begin errors++; $display("[TB] FAIL bp_pop4 got %b/%0d/%h/%0d want 1/14/104/0", regWrite, RD, writeData, fifo_count); end
        idle_inputs();
        tick();
        checks++; if ({regWrite, busy, err} !== {1'b0, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL bp_end got we %b busy %h err %b want 0/0/0", regWrite, busy, err); end
    endtask

    task automatic test_latency();
        mdu_issue = 1'b1; mdu_issue_rd = 5'd3;
        tick();
        mdu_issue = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'hA5;
        tick();
        mdu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        checks++; if ({regWrite, RD, writeData, fifo_count, busy[3]} !== {1'b1, 5'd3, 32'hA5, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL byp_k1 got %b/%0d/%h/%0d/%b want 1/3/a5/0/0", regWrite, RD, writeData, fifo_count, busy[3]); end
`else
        checks++; if ({regWrite, fifo_count, busy[3]} !== {1'b0, 3'd1, 1'b1}) begin errors++; $display("[TB] FAIL lat_k1 got we %b count %0d busy3 %b want 0/1/1", regWrite, fifo_count, busy[3]); end
        tick();
        checks++; if ({regWrite, RD, writeData, fifo_count, busy[3]} !== {1'b1, 5'd3, 32'hA5, 3'd0, 1'b0}) begin errors++; $display("[TB] FAIL lat_k2 got %b/%0d/%h/%0d/%b want 1/3/a5/0/0", regWrite, RD, writeData, fifo_count, busy[3]); end
`endif
        tick();
        checks++; if (regWrite !== 1'b0) begin errors++; $display("[TB] FAIL lat_after got %b want 0", regWrite); end
    endtask

    task automatic test_errors();
        mdu_issue = 1'b1; mdu_issue_rd = 5'd4;
        tick();
        mdu_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h21;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'h44;
        tick();
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL err_push got count %0d want 1", fifo_count); end
        alu_valid = 1'b0; mdu_valid = 1'b0;
        mdu_issue = 1'b1; mdu_issue_rd = 5'd4;
        tick();
        mdu_issue = 1'b0;
        checks++; if ({regWrite, RD, writeData} !== {1'b1, 5'd4, 32'h44}) begin errors++; $display("[TB] FAIL err_reissue_write got %b/%0d/%h want 1/4/44", regWrite, RD, writeData); end
        checks++; if ({busy[4], err} !== 2'b10) begin errors++; $display("[TB] FAIL err_reissue got busy4 %b err %b want 1/0", busy[4], err); end
        mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
        tick();
        mdu_issue = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL err_pre_waw got %b want 0", err); end
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick();
        alu_valid = 1'b0;
        checks++; if ({err, regWrite, RD} !== {1'b1, 1'b1, 5'd9}) begin errors++; $display("[TB] FAIL err_waw got err %b we %b rd %0d want 1/1/9", err, regWrite, RD); end
        tick();
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 3; i++) begin
            mdu_issue = 1'b1; mdu_issue_rd = 5'(1 + i);
            tick();
        end
        mdu_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB;
        for (int i = 0; i < 3; i++) begin
            mdu_valid = 1'b1; mdu_rd = 5'(1 + i); mdu_data = 32'(32'h300 + i);
            tick();
        end
        mdu_valid = 1'b0; alu_valid = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL rmd_fill got %0d want 3", fifo_count); end
        tick();
        checks++; if ({regWrite, RD, fifo_count} !== {1'b1, 5'd1, 3'd2}) begin errors++; $display("[TB] FAIL rmd_drain got %b/%0d/%0d want 1/1/2", regWrite, RD, fifo_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({regWrite, fifo_count, busy, err} !== {1'b0, 3'd0, 32'd0, 1'b0}) begin errors++; $display("[TB] FAIL rmd_async got we %b count %0d busy %h err %b want 0/0/0/0", regWrite, fifo_count, busy, err); end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({regWrite, fifo_count} !== {1'b0, 3'd0}) begin errors++; $display("[TB] FAIL rmd_after%0d got we %b count %0d want 0/0", i, regWrite, fifo_count); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_contention();
        test_backpressure();
        test_latency();
        test_errors();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
